// File: rtl/mpram_write_scheduler_if.sv
// Write-side bus of the XOR multi-port RAM scheduler.
// Carries the requester valid/ready handshake (REQ_NUM lanes) and the
// RAM write-port bundle (WPORTS_NUM lanes).
//   master : requester/RAM side (drives requests, observes ready and ports)
//   slave  : scheduler side (accepts requests, drives ready and RAM ports)
interface mpram_write_scheduler_if #(
  parameter int REQ_NUM    = 8,
  parameter int WPORTS_NUM = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64
);
  logic [REQ_NUM-1:0]                     req_valid_i;
  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]     req_addr_i;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]     req_data_i;
  logic [REQ_NUM-1:0]                     req_ready_o;
  logic [WPORTS_NUM-1:0]                  en_w_o;
  logic [WPORTS_NUM-1:0]                  we_o;
  logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0]  waddr_o;
  logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0]  wdata_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, en_w_o, we_o, waddr_o, wdata_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, en_w_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/mpram_write_scheduler.sv
// Write scheduler in front of an XOR-based multi-port RAM.
// After reset or clear_i it zeroes every RAM entry, WPORTS_NUM per cycle
// (INIT), then packs up to WPORTS_NUM requests per cycle onto the write
// ports using a round-robin scan, never issuing two same-cycle writes to
// one address (the XOR scheme cannot merge them).
// Ports:
//   clk         : clock, posedge
//   a_rst_n     : asynchronous reset, active low
//   clear_i     : re-zero the RAM; honoured only in RUN
//   init_done_o : high while in RUN
//   bus         : request handshake (ready is combinational on valid) and
//                 registered RAM write ports (1-cycle latency)
module mpram_write_scheduler #(
  parameter int DATA_DEPTH = 128,
  parameter int DATA_WIDTH = 64,
  parameter int REQ_NUM    = 8,
  parameter int WPORTS_NUM = 4
) (
  input  logic                   clk,
  input  logic                   a_rst_n,
  input  logic                   clear_i,
  output logic                   init_done_o,
  mpram_write_scheduler_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam int PTR_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [PTR_W-1:0]                      ptr_q, ptr_d;
  logic [WPORTS_NUM-1:0]                 en_w_q, en_w_d;
  logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [REQ_NUM-1:0]                    grant;
  logic [31:0]                           sweep_addr;
  logic [31:0]                           idx;
  logic [31:0]                           n_grant;
  logic [31:0]                           last_idx;
  logic [31:0]                           nxt_ptr;
  logic                                  conflict;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    en_w_d     = '0;
    waddr_d    = '0;
    wdata_d    = '0;
    grant      = '0;
    sweep_addr = '0;
    idx        = '0;
    n_grant    = '0;
    last_idx   = '0;
    nxt_ptr    = '0;
    conflict   = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Zero sweep; lanes past the end of the RAM stay disabled.
        for (int p = 0; p < WPORTS_NUM; p++) begin
          sweep_addr = 32'(cnt_q) + 32'(p);
          if (sweep_addr < 32'(DATA_DEPTH)) begin
            en_w_d[p]  = 1'b1;
            waddr_d[p] = sweep_addr[ADDR_WIDTH-1:0];
          end
        end
        if (32'(cnt_q) + 32'(WPORTS_NUM) >= 32'(DATA_DEPTH)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(WPORTS_NUM);
        end
      end
      ST_RUN: begin
        // Circular scan starting at ptr; the k-th winner lands on port k.
        for (int i = 0; i < REQ_NUM; i++) begin
          idx = 32'(ptr_q) + 32'(i);
          if (idx >= 32'(REQ_NUM)) idx = idx - 32'(REQ_NUM);
          for (int r = 0; r < REQ_NUM; r++) begin
            if (32'(r) == idx && bus.req_valid_i[r] && n_grant < 32'(WPORTS_NUM)) begin
              conflict = 1'b0;
              for (int k = 0; k < WPORTS_NUM; k++) begin
                if (32'(k) < n_grant && waddr_d[k] == bus.req_addr_i[r]) conflict = 1'b1;
              end
              // A same-address loser is simply not granted and retries.
              if (!conflict) begin
                grant[r] = 1'b1;
                for (int k = 0; k < WPORTS_NUM; k++) begin
                  if (32'(k) == n_grant) begin
                    en_w_d[k]  = 1'b1;
                    waddr_d[k] = bus.req_addr_i[r];
                    wdata_d[k] = bus.req_data_i[r];
                  end
                end
                n_grant  = n_grant + 32'd1;
                last_idx = 32'(r);
              end
            end
          end
        end
        if (n_grant != 32'd0) begin
          nxt_ptr = last_idx + 32'd1;
          if (nxt_ptr >= 32'(REQ_NUM)) nxt_ptr = nxt_ptr - 32'(REQ_NUM);
          ptr_d = PTR_W'(nxt_ptr);
        end
        // This cycle's grants still go out; the sweep starts next cycle.
        if (clear_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      en_w_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      en_w_q  <= en_w_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.en_w_o      = en_w_q;
  assign bus.we_o        = en_w_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.wdata_o     = wdata_q;
  assign init_done_o     = (state_q == ST_RUN);
endmodule

// File: tb/tb_mpram_write_scheduler.sv
// Directed bench for mpram_write_scheduler: zero sweep (128 and 130 deep),
// table of RUN arbitration vectors, clear_i and mid-sweep async reset.
module tb_mpram_write_scheduler;
  localparam int DEPTH  = 128;
  localparam int DEPTH2 = 130;
  localparam int DW     = 64;
  localparam int RN     = 8;
  localparam int WP     = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int AW2    = $clog2(DEPTH2);
  localparam int NV     = 9;

  logic clk = 1'b0;
  logic a_rst_n;
  logic clear_i;
  logic init_done;
  logic init_done2;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mpram_write_scheduler_if #(.REQ_NUM(RN), .WPORTS_NUM(WP), .ADDR_WIDTH(AW),  .DATA_WIDTH(DW)) bus ();
  mpram_write_scheduler_if #(.REQ_NUM(RN), .WPORTS_NUM(WP), .ADDR_WIDTH(AW2), .DATA_WIDTH(DW)) bus2 ();

  mpram_write_scheduler #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .REQ_NUM(RN), .WPORTS_NUM(WP)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .clear_i(clear_i), .init_done_o(init_done), .bus(bus)
  );

  mpram_write_scheduler #(.DATA_DEPTH(DEPTH2), .DATA_WIDTH(DW), .REQ_NUM(RN), .WPORTS_NUM(WP)) dut2 (
    .clk(clk), .a_rst_n(a_rst_n), .clear_i(1'b0), .init_done_o(init_done2), .bus(bus2)
  );

  typedef struct {
    logic [RN-1:0]         valid;
    logic [RN-1:0][AW-1:0] addr;
    logic [RN-1:0]         rdy;
    logic [WP-1:0]         en;
    logic [WP-1:0][AW-1:0] waddr;
    logic [WP-1:0][3:0]    src;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [DW-1:0] dval(input int r);
    return 64'hC0DE_0000_0000_0000 + 64'(r);
  endfunction

  function automatic vec_t mk(input logic [RN-1:0] v, input logic [RN-1:0][AW-1:0] a,
                              input logic [RN-1:0] rd, input logic [WP-1:0] e,
                              input logic [WP-1:0][AW-1:0] wa, input logic [WP-1:0][3:0] s);
    vec_t t;
    t.valid = v; t.addr = a; t.rdy = rd; t.en = e; t.waddr = wa; t.src = s;
    return t;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec_out(input int j);
    logic [WP-1:0][DW-1:0] ewd;
    for (int p = 0; p < WP; p++)
      ewd[p] = vecs[j].en[p] ? dval(int'(vecs[j].src[p])) : '0;
    chk($sformatf("v%0d_en", j),    bus.en_w_o,  vecs[j].en);
    chk($sformatf("v%0d_we", j),    bus.we_o,    vecs[j].en);
    chk($sformatf("v%0d_waddr", j), bus.waddr_o, vecs[j].waddr);
    chk($sformatf("v%0d_wdata", j), bus.wdata_o, ewd);
  endtask

  initial begin
    logic [WP-1:0][AW-1:0] ew;
    logic [DEPTH-1:0]      seen;
    int                    dup;
    int                    a2;

    // RUN vectors, applied back to back starting with ptr=0.
    vecs[0] = mk(8'hFF, {7'h07,7'h06,7'h05,7'h04,7'h03,7'h02,7'h01,7'h00}, 8'h0F, 4'hF,
                 {7'h03,7'h02,7'h01,7'h00}, {4'd3,4'd2,4'd1,4'd0});
    vecs[1] = mk(8'hF0, {7'h07,7'h06,7'h05,7'h04,7'h03,7'h02,7'h01,7'h00}, 8'hF0, 4'hF,
                 {7'h07,7'h06,7'h05,7'h04}, {4'd7,4'd6,4'd5,4'd4});
    vecs[2] = mk(8'h22, {7'h00,7'h00,7'h10,7'h00,7'h00,7'h00,7'h10,7'h00}, 8'h02, 4'h1,
                 {7'h00,7'h00,7'h00,7'h10}, {4'd0,4'd0,4'd0,4'd1});
    vecs[3] = mk(8'h20, {7'h00,7'h00,7'h10,7'h00,7'h00,7'h00,7'h10,7'h00}, 8'h20, 4'h1,
                 {7'h00,7'h00,7'h00,7'h10}, {4'd0,4'd0,4'd0,4'd5});
    vecs[4] = mk(8'h00, '0, 8'h00, 4'h0, '0, '0);
    vecs[5] = mk(8'hFF, {7'h27,7'h26,7'h25,7'h24,7'h23,7'h22,7'h21,7'h20}, 8'hC3, 4'hF,
                 {7'h21,7'h20,7'h27,7'h26}, {4'd1,4'd0,4'd7,4'd6});
    vecs[6] = mk(8'h3C, {7'h00,7'h00,7'h30,7'h31,7'h30,7'h30,7'h00,7'h00}, 8'h14, 4'h3,
                 {7'h00,7'h00,7'h31,7'h30}, {4'd0,4'd0,4'd4,4'd2});
    vecs[7] = mk(8'hFF, {7'h47,7'h46,7'h45,7'h44,7'h43,7'h42,7'h41,7'h40}, 8'hE1, 4'hF,
                 {7'h40,7'h47,7'h46,7'h45}, {4'd0,4'd7,4'd6,4'd5});
    vecs[8] = mk(8'h01, {7'h00,7'h00,7'h00,7'h00,7'h00,7'h00,7'h00,7'h7F}, 8'h01, 4'h1,
                 {7'h00,7'h00,7'h00,7'h7F}, {4'd0,4'd0,4'd0,4'd0});

    a_rst_n = 1'b0;
    clear_i = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_addr_i   = '0;
    bus2.req_valid_i = '0;
    bus2.req_addr_i  = '0;
    bus2.req_data_i  = '0;
    for (int r = 0; r < RN; r++) bus.req_data_i[r] = dval(r);
    seen = '0;
    dup  = 0;

    // Reset state
    #12;
    chk("rst_en",    bus.en_w_o,      0);
    chk("rst_waddr", bus.waddr_o,     0);
    chk("rst_wdata", bus.wdata_o,     0);
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_done",  init_done,       0);
    @(negedge clk);
    a_rst_n = 1'b1;

    // Zero sweep on both depths
    for (int c = 0; c <= 32; c++) begin
      @(posedge clk); #1;
      if (c < 32) begin
        for (int p = 0; p < WP; p++) ew[p] = AW'(4 * c + p);
        chk("sweep_en",    bus.en_w_o,  4'hF);
        chk("sweep_waddr", bus.waddr_o, ew);
        chk("sweep_wdata", bus.wdata_o, 0);
        for (int p = 0; p < WP; p++) begin
          if (bus.en_w_o[p]) begin
            if (seen[bus.waddr_o[p]]) dup++;
            seen[bus.waddr_o[p]] = 1'b1;
          end
        end
      end else begin
        chk("run_idle_en", bus.en_w_o, 0);
      end
      chk("sweep_done",  init_done,       (c >= 31));
      chk("sweep_ready", bus.req_ready_o, 0);
      for (int p = 0; p < WP; p++) begin
        a2 = 4 * c + p;
        chk("sweep2_en", bus2.en_w_o[p], (a2 < DEPTH2));
        if (a2 < DEPTH2) chk("sweep2_waddr", bus2.waddr_o[p], a2);
      end
      chk("sweep2_wdata", bus2.wdata_o, 0);
      chk("sweep2_done",  init_done2, (c == 32));
    end
    chk("sweep_cover", seen, {DEPTH{1'b1}});
    chk("sweep_dup",   dup,  0);

    // Table-driven RUN arbitration
    for (int i = 0; i <= NV; i++) begin
      @(posedge clk); #1;
      if (i > 0) check_vec_out(i - 1);
      if (i < NV) begin
        bus.req_valid_i = vecs[i].valid;
        bus.req_addr_i  = vecs[i].addr;
        @(negedge clk);
        chk($sformatf("v%0d_ready", i), bus.req_ready_o, vecs[i].rdy);
      end else begin
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
      end
    end

    // clear_i with req3 pending behind a same-address grant to req1 (ptr=1)
    bus.req_valid_i   = 8'h0A;
    bus.req_addr_i[1] = 7'h05;
    bus.req_addr_i[3] = 7'h05;
    clear_i = 1'b1;
    @(negedge clk);
    chk("clr_ready", bus.req_ready_o, 8'h02);
    @(posedge clk); #1;
    clear_i = 1'b0;
    bus.req_valid_i = 8'h08;
    chk("clr_en",     bus.en_w_o,      4'h1);
    chk("clr_waddr0", bus.waddr_o[0],  7'h05);
    chk("clr_wdata0", bus.wdata_o[0],  dval(1));
    chk("clr_done",   init_done,       0);
    chk("clr_ready2", bus.req_ready_o, 0);
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < WP; p++) ew[p] = AW'(4 * c + p);
      chk("csweep_en",    bus.en_w_o,  4'hF);
      chk("csweep_waddr", bus.waddr_o, ew);
      chk("csweep_wdata", bus.wdata_o, 0);
      chk("csweep_done",  init_done,   (c == 31));
      if (c < 31) chk("csweep_ready", bus.req_ready_o, 0);
    end
    chk("post_clr_ready", bus.req_ready_o, 8'h08);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    chk("post_clr_en",     bus.en_w_o,     4'h1);
    chk("post_clr_waddr0", bus.waddr_o[0], 7'h05);
    chk("post_clr_wdata0", bus.wdata_o[0], dval(3));

    // Async reset in the middle of a sweep
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("mid_en",     bus.en_w_o,     4'hF);
    chk("mid_waddr0", bus.waddr_o[0], 7'd36);
    a_rst_n = 1'b0;
    #1;
    chk("arst_en",    bus.en_w_o,      0);
    chk("arst_we",    bus.we_o,        0);
    chk("arst_waddr", bus.waddr_o,     0);
    chk("arst_wdata", bus.wdata_o,     0);
    chk("arst_ready", bus.req_ready_o, 0);
    chk("arst_done",  init_done,       0);
    chk("arst_done2", init_done2,      0);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_en",    bus.en_w_o,  4'hF);
    chk("restart_waddr", bus.waddr_o, {7'd3, 7'd2, 7'd1, 7'd0});
    chk("restart_done",  init_done,   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mpram_write_scheduler.md
Name: mpram_write_scheduler

Overview:
- Front-end scheduler for the XOR-based multi-port RAM's write side.
- Accepts write requests from REQ_NUM requesters over valid/ready and packs up to WPORTS_NUM of them per cycle onto the RAM write ports.
- Uses a round-robin pointer for fairness, and never issues two same-cycle writes to the same address, which the XOR scheme cannot resolve.
- After reset, or on clear_i, it sweeps the whole RAM to zero through all write ports before accepting requests.

Parameters:
- DATA_DEPTH, 128, RAM entries.
- DATA_WIDTH, 64, word width.
- REQ_NUM, 8, number of requesters (>= 1).
- WPORTS_NUM, 4, RAM write ports driven (>= 1, <= REQ_NUM).
- ADDR_WIDTH, $clog2(DATA_DEPTH), localparam.

Ports:
- clk  input  1  single clock, all logic on posedge.
- a_rst_n  input  1  asynchronous reset, active low.
- clear_i  input  1  request re-zeroing of the RAM; sampled in RUN only.
- req_valid_i  input  [REQ_NUM]  write request valid.
- req_addr_i  input  [REQ_NUM][ADDR_WIDTH]  request address.
- req_data_i  input  [REQ_NUM][DATA_WIDTH]  request data.
- req_ready_o  output  [REQ_NUM]  request accepted this cycle (handshake = valid & ready).
- en_w_o  output  [WPORTS_NUM]  RAM write-port enable.
- we_o  output  [WPORTS_NUM]  RAM full-word write enable; always equals en_w_o.
- waddr_o  output  [WPORTS_NUM][ADDR_WIDTH]  RAM write address.
- wdata_o  output  [WPORTS_NUM][DATA_WIDTH]  RAM write data.
- init_done_o  output  1  high while in RUN.

Behaviour:
- Reset (async, a_rst_n=0):
  - State INIT, clear counter cnt=0, rr pointer ptr=0.
  - en_w_o/we_o/waddr_o/wdata_o = 0, init_done_o=0, req_ready_o=0.
  - Reset asserted at any time, including mid-INIT, aborts immediately; the sweep restarts at address 0 after release.
- All port outputs are registered. Content chosen in cycle t appears after edge t+1 (1-cycle latency).
- FSM INIT:
  - req_ready_o=0.
  - Each cycle, port p is loaded with addr cnt+p, data 0, en=1 if cnt+p < DATA_DEPTH, else en=0.
  - cnt += WPORTS_NUM per cycle.
  - At the edge that loads the last batch (cnt+WPORTS_NUM >= DATA_DEPTH), go to RUN and clear cnt.
  - Sweep length = ceil(DATA_DEPTH/WPORTS_NUM) cycles.
- FSM RUN:
  - init_done_o=1.
  - Combinational grant: scan requesters in circular order ptr, ptr+1, ..., ptr+REQ_NUM-1.
  - Requester r is granted if req_valid_i[r], fewer than WPORTS_NUM grants so far, and req_addr_i[r] differs from every address already granted this cycle.
  - The k-th grant in scan order is loaded into port k; ports beyond the grant count get en=0 (addr/data don't-care, hold 0).
  - req_ready_o[r] = granted[r]. Ready may depend on valid.
  - A requester must hold valid/addr/data stable until ready.
  - A same-address loser stays pending and is reconsidered next cycle.
  - ptr <= (index of last grant + 1) mod REQ_NUM if any grant; unchanged otherwise.
  - clear_i=1 in RUN: that cycle's grants still complete normally. Next state is INIT with cnt=0 and ptr=0, so req_ready_o=0 from the following cycle. init_done_o drops at the same edge.
- Invariants:
  - No two enabled ports ever carry the same waddr_o in a cycle.
  - No request is lost or duplicated.
  - With all requesters continuously valid on distinct addresses, each requester is granted at least once every ceil(REQ_NUM/WPORTS_NUM) cycles.
- Wrap-around:
  - ptr modulo REQ_NUM, using compare-and-subtract, not a power-of-2 mask.
  - cnt width ADDR_WIDTH+1, so that the DATA_DEPTH boundary does not overflow.

Test Plan (DATA_DEPTH=128, REQ_NUM=8, WPORTS_NUM=4 unless noted):
1. Release reset, no requests -> en_w_o=4'b1111 for 32 consecutive cycles; waddr_o covers 0..127 exactly once with wdata_o=0; init_done_o=1 from the edge loading addrs 124..127; req_ready_o=0 throughout INIT.
2. RUN, ptr=0, all 8 valid with distinct addrs 0x00..0x07 -> cycle 1 ready=8'h0F, ports 0..3 get reqs 0..3 next edge, ptr=4. Cycle 2 ready=8'hF0, ptr=0.
3. RUN, ptr=0, req1 and req5 both addr 0x10 -> cycle 1 ready=8'h02 only, port0 addr 0x10 with data1. Cycle 2 ready=8'h20, port0 carries data5, ports1..3 en=0.
4. DATA_DEPTH=130 -> 33 INIT cycles. Final batch: ports 0,1 write addrs 128,129; ports 2,3 en=0. No address >= 130 is ever enabled.
5. RUN with req3 pending, pulse clear_i -> that cycle's grant issues. Next cycle ready=0 and init_done_o=0, followed by a full 32-cycle zero sweep. Afterwards ptr=0 and req3 is granted on port0.
6. Assert a_rst_n=0 during INIT cycle 10 -> all outputs 0 immediately (asynchronously). After release, the sweep restarts at waddr_o=0..3.
